// File: rtl/prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// prefetch_queue_if
//   Bundles the prefetch queue's flush control, ROM fetch port and decode
//   window into one interface.
//   slave  modport : the prefetch queue itself
//   master modport : the environment driving it (core control, ROM, decode)
//   Signals:
//     flush/flush_addr      restart request and new linear address
//     rom_en/rom_addr       ROM read request (one per cycle at most)
//     rom_data              ROM response, valid the cycle after rom_en
//     q_data/q_count/q_ip   decode window, valid byte count, address of byte 0
//     consume               bytes retired by decode this cycle
//     q_underflow           one-cycle pulse after an over-consume
// -----------------------------------------------------------------------------
interface prefetch_queue_if #(
  parameter int DEPTH   = 6,
  parameter int FETCH_W = 2,
  parameter int OUT_W   = 6,
  parameter int ADDR_W  = 20
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(OUT_W + 1);

  logic                  flush;
  logic [ADDR_W-1:0]     flush_addr;
  logic                  rom_en;
  logic [ADDR_W-1:0]     rom_addr;
  logic [FETCH_W*8-1:0]  rom_data;
  logic [OUT_W*8-1:0]    q_data;
  logic [CW-1:0]         q_count;
  logic [ADDR_W-1:0]     q_ip;
  logic [NW-1:0]         consume;
  logic                  q_underflow;

  modport slave (
    input  flush, flush_addr, rom_data, consume,
    output rom_en, rom_addr, q_data, q_count, q_ip, q_underflow
  );

  modport master (
    output flush, flush_addr, rom_data, consume,
    input  rom_en, rom_addr, q_data, q_count, q_ip, q_underflow
  );
endinterface

// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//   Instruction prefetch queue on the bus-interface side of the core. Issues
//   FETCH_W-byte ROM reads into a DEPTH-byte circular buffer and presents the
//   oldest OUT_W bytes to decode as an aligned window. Decode retires 0..OUT_W
//   bytes per cycle; a flush discards queued and in-flight bytes and restarts
//   fetching at flush_addr.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   prefetch_queue_if.slave (flush, ROM port, decode window)
// -----------------------------------------------------------------------------
module prefetch_queue #(
  parameter int DEPTH   = 6,
  parameter int FETCH_W = 2,
  parameter int OUT_W   = 6,
  parameter int ADDR_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  prefetch_queue_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [7:0] byte_t;

  // Arguments never exceed 2*DEPTH-1, so one conditional subtract is a
  // complete modulo-DEPTH reduction.
  function automatic logic [PW-1:0] wrap_idx(input int unsigned v);
    int unsigned r;
    r = (v >= int'(DEPTH)) ? v - int'(DEPTH) : v;
    return PW'(r);
  endfunction

  byte_t             buf_q [DEPTH];
  byte_t             buf_d [DEPTH];
  logic [PW-1:0]     head_q,       head_d;
  logic [CW-1:0]     count_q,      count_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] q_ip_q,       q_ip_d;
  logic              in_flight_q,  in_flight_d;
  logic              underflow_q,  underflow_d;

  logic              rom_en;
  int                eff;
  int                fill_n;
  logic [OUT_W*8-1:0] q_data_c;

  // Issue only when the queue can absorb this request on top of the one
  // already in flight; registered count only, so consume never reaches rom_en.
  assign rom_en = !rst && !bus.flush &&
                  (int'(count_q) + (in_flight_q ? FETCH_W : 0) + FETCH_W <= DEPTH);

  always_comb begin
    buf_d        = buf_q;
    head_d       = head_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    q_ip_d       = q_ip_q;
    in_flight_d  = rom_en;
    underflow_d  = 1'b0;
    eff          = (int'(bus.consume) > int'(count_q)) ? int'(count_q) : int'(bus.consume);
    fill_n       = in_flight_q ? FETCH_W : 0;

    if (rst) begin
      head_d       = '0;
      count_d      = '0;
      fetch_addr_d = '0;
      q_ip_d       = '0;
      in_flight_d  = 1'b0;
    end else if (bus.flush) begin
      // A response arriving now belongs to the abandoned stream: drop it.
      head_d       = '0;
      count_d      = '0;
      fetch_addr_d = bus.flush_addr;
      q_ip_d       = bus.flush_addr;
      in_flight_d  = 1'b0;
    end else begin
      underflow_d = int'(bus.consume) > int'(count_q);
      // Tail is computed from the pre-consume head/count; the issue rule keeps
      // it clear of every byte still queued, including the ones retired now.
      if (in_flight_q) begin
        for (int k = 0; k < FETCH_W; k++) begin
          buf_d[wrap_idx(int'(head_q) + int'(count_q) + k)] = bus.rom_data[8*k +: 8];
        end
      end
      head_d  = wrap_idx(int'(head_q) + eff);
      q_ip_d  = q_ip_q + ADDR_W'(eff);
      count_d = CW'(int'(count_q) - eff + fill_n);
      if (rom_en) begin
        fetch_addr_d = fetch_addr_q + ADDR_W'(FETCH_W);
      end
    end
  end

  // NOTE: reset is folded into the _d logic above, so every state register
  // here is a plain non-blocking copy; blocking here would race other flops.
  always_ff @(posedge clk) begin
    head_q       <= head_d;
    count_q      <= count_d;
    fetch_addr_q <= fetch_addr_d;
    q_ip_q       <= q_ip_d;
    in_flight_q  <= in_flight_d;
    underflow_q  <= underflow_d;
  end

  // NOTE: the byte store has no reset; stale contents are masked by count_q.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // Window: oldest byte in the low lane, lanes beyond the valid count read 0.
  always_comb begin
    q_data_c = '0;
    for (int k = 0; k < OUT_W; k++) begin
      if (k < int'(count_q)) begin
        q_data_c[8*k +: 8] = buf_q[wrap_idx(int'(head_q) + k)];
      end
    end
  end

  assign bus.rom_en      = rom_en;
  assign bus.rom_addr    = fetch_addr_q;
  assign bus.q_data      = q_data_c;
  assign bus.q_count     = count_q;
  assign bus.q_ip        = q_ip_q;
  assign bus.q_underflow = underflow_q;

endmodule
